// File: rtl/uart_blk_tx_pkg.sv
// uart_blk_tx_pkg: shared bit-rate default, FSM encodings and frame width.
// UART_TX_PARITY_EN widens the frame with an even-parity bit.
package uart_blk_tx_pkg;
  localparam int UART_NT = 434;
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] PAR   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: single-frame serialiser (8N1, or 8E1 with UART_TX_PARITY_EN).
// done marks the last cycle of the stop bit so a reload there leaves no gap.
module uart_byte_tx
  import uart_blk_tx_pkg::*;
#(
  parameter int NT = UART_NT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       txd,
  output logic       busy,
  output logic       done
);
  logic [2:0]  state;
  logic [11:0] tick;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        wrap;
`ifdef UART_TX_PARITY_EN
  logic        par;
`endif
  assign wrap = tick == 12'(NT - 1);
  assign busy = state != IDLE;
  assign done = state == STOP && wrap;
  always_ff @(posedge clk)
    if (rst) begin
      state   <= IDLE;
      tick    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      txd     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else if (load && (!busy || done)) begin
      state   <= START;
      tick    <= '0;
      bit_cnt <= '0;
      shift   <= data;
      txd     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par     <= ^data;
`endif
    end else if (busy) begin
      tick <= wrap ? '0 : tick + 12'd1;
      if (wrap)
        case (state)
          START: begin
            state <= DATA;
            txd   <= shift[0];
            shift <= shift >> 1;
          end
          DATA: begin
            bit_cnt <= bit_cnt + 3'd1;
            shift   <= shift >> 1;
`ifdef UART_TX_PARITY_EN
            state   <= bit_cnt == 3'd7 ? PAR : DATA;
            txd     <= bit_cnt == 3'd7 ? par : shift[0];
`else
            state   <= bit_cnt == 3'd7 ? STOP : DATA;
            txd     <= bit_cnt == 3'd7 ? 1'b1 : shift[0];
`endif
          end
`ifdef UART_TX_PARITY_EN
          PAR: begin
            state <= STOP;
            txd   <= 1'b1;
          end
`endif
          default: state <= IDLE;
        endcase
    end
endmodule

// File: rtl/uart_blk_tx.sv
// uart_blk_tx: sends adr_COM, adr_REG, dat_REG back-to-back on txd.
// UART_TX_PARITY_EN (optional) adds an even-parity bit to every frame.
module uart_blk_tx
  import uart_blk_tx_pkg::*;
#(
  parameter int NT    = UART_NT,
  parameter int NBYTE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] adr_COM,
  input  logic [7:0] adr_REG,
  input  logic [7:0] dat_REG,
  output logic       txd,
  output logic       busy,
  output logic       done
);
  logic [7:0] reg_b, dat_b, next_b;
  logic [1:0] byte_cnt;
  logic       accept, load, last, frame_busy, frame_done;
  assign accept = start && !busy && !frame_busy;
  assign last   = byte_cnt == 2'(NBYTE - 1);
  assign load   = accept || (frame_done && !last);
  // byte 0 goes straight to the serialiser; the rest wait in the latches
  assign next_b = accept ? adr_COM : byte_cnt == 2'd0 ? reg_b : dat_b;
  uart_byte_tx #(.NT(NT)) u_byte (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .data (next_b),
    .txd  (txd),
    .busy (frame_busy),
    .done (frame_done)
  );
  always_ff @(posedge clk)
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      byte_cnt <= '0;
      reg_b    <= '0;
      dat_b    <= '0;
    end else begin
      done <= frame_done && last;
      if (accept) begin
        busy     <= 1'b1;
        byte_cnt <= '0;
        reg_b    <= adr_REG;
        dat_b    <= dat_REG;
      end else if (frame_done) begin
        busy     <= !last;
        byte_cnt <= last ? 2'd0 : byte_cnt + 2'd1;
      end
    end
endmodule

// File: doc/uart_blk_tx.md
Name: uart_blk_tx

Overview:
- Transmit-side counterpart of the UART command-block link.
- Serialises a 3-byte block (command address, register address, register data) onto one TXD line.
- Frame format: 8N1, LSB first; bytes are sent back-to-back with no inter-byte gap.
- Sits between the register/response logic and the board TX pin. Output is directly compatible with the existing block receiver: byte order adr_COM, adr_REG, dat_REG.

Parameters:
- NT, 434, clocks per UART bit (50 MHz / 115200). Legal range 2..4095; the tick counter is 12 bits.
- NBYTE, 3, bytes per block; fixed at 3, present for readability only.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to send a block; sampled only when busy==0
- adr_COM  in  8  byte 0 (command address); latched on accepted start
- adr_REG  in  8  byte 1 (register address); latched on accepted start
- dat_REG  in  8  byte 2 (register data); latched on accepted start
- txd  out  1  serial line; idle high
- busy  out  1  high while a block is in flight
- done  out  1  one-cycle pulse at block completion

Behaviour:
- Reset values (rst sampled high): txd=1, busy=0, done=0. State=IDLE; tick, bit and byte counters=0; shift/latch registers=0.
- Accept: start & !busy at edge E. At E:
  - the three input bytes are latched;
  - busy=1;
  - state=START;
  - tick=0;
  - byte counter=0.
- Start during busy is ignored. Input bytes may change freely after acceptance.
- Bit timing: each bit occupies exactly NT clock cycles. txd is registered and changes only at bit boundaries. A bit boundary is the cycle where tick==NT-1; tick then wraps to 0.
- FSM:
  - IDLE → START on accept.
  - START (txd=0, 1 bit) → DATA.
  - DATA (txd=shift[0], 8 bits, shift right each boundary) → STOP after the 8th bit. Bit counter runs 0..7.
  - STOP (txd=1, 1 bit) → START of the next byte if byte counter<2 (counter +1, next byte loaded into shift reg); otherwise → IDLE.
- Frame timing: txd=0 is visible from cycle E+1. Block length is 30*NT cycles. The final stop bit ends at E+30*NT.
- Completion: in the cycle following the end of the last stop bit, done=1 for one cycle and busy=0 in the same cycle. txd stays 1.
- Back-to-back: start is accepted in the done cycle, because busy is already 0. The next start bit begins the following cycle, with no extra idle bit.
- rst mid-block: next cycle txd=1, busy=0, done=0, FSM=IDLE. The partial frame is abandoned and no done pulse is generated.
- rst and start in the same cycle: rst wins and start is dropped.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: an even-parity bit is inserted between DATA and STOP via an extra state PAR, with txd = XOR of the 8 data bits. Frame becomes 11 bits; block = 33*NT cycles; done timing shifts accordingly.
- Undefined: the PAR state and parity logic are absent; 8N1 only, 30*NT cycles.

Decomposition:
- Shared constants file: UART_Nt default, FSM state encodings (IDLE/START/DATA/PAR/STOP) and the bits-per-frame constant.
- Sub-module uart_byte_tx: single-frame serialiser with load/busy/done and its own tick counter.
- uart_blk_tx owns the byte sequencer, the latches and the block done/busy.

Test Plan (NT=16):
- Reset then idle 100 cycles → txd=1, busy=0, done=0 throughout.
- start with 0xA5,0x3C,0x0F at edge E → txd segments (16 cycles each) 0,1,0,1,0,0,1,0,1,1 for 0xA5, then the 0x3C frame, then the 0x0F frame. busy=1 from E to E+480; done=1 only at cycle E+481.
- start pulsed again at E+100 while busy → ignored; waveform identical to the previous test; a single done pulse.
- start held high continuously with bytes 0x00,0xFF,0x81 → second block's start bit begins the cycle after done. No high gap beyond the stop bit; 2 done pulses exactly 481 cycles apart.
- rst asserted at E+200 mid-block → txd=1 and busy=0 at E+201; no done. A subsequent start sends a full clean block.
- Loopback txd into the existing UART block receiver with 0x12,0x34,0x56 → receiver outputs 0x12/0x34/0x56. With UART_TX_PARITY_EN, check the parity bit: 0x12→0, 0x34→1, 0x56→0, with block length 528 cycles.
